// File: rtl/axis_bf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_bf_pkg
//  Purpose  : Shared widths, weight constants and packet FSM states for the
//             beamforming datapath.
//  Revision : 1.0  initial release
// ============================================================================
package axis_bf_pkg;

   localparam int BF_DATA_WIDTH   = 128;
   localparam int BF_SAMPLE_WIDTH = 16;
   localparam int BF_WEIGHT_WIDTH = 8;
   localparam int BF_SAMPLES      = BF_DATA_WIDTH / BF_SAMPLE_WIDTH;

   // wr = +127 (~1.0 in Q1.7), wi = 0
   localparam logic [15:0] UNITY_WEIGHT = 16'h007F;
   localparam int          ROUND_CONST  = 64;
   localparam int          WEIGHT_FRAC  = 7;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } pkt_state_t;

endpackage : axis_bf_pkg
`default_nettype wire

// File: rtl/axis_cweight_mult_cmult_lane.sv
`default_nettype none
// ============================================================================
//  Module   : cmult_lane
//  Purpose  : One sample's complex multiply by a Q1.7 weight: product stage,
//             then combine/round/limit stage. Both stages share one enable.
//             Build option AXIS_CWEIGHT_SAT_EN selects saturation over wrap.
//  Revision : 1.0  initial release
// ============================================================================
module cmult_lane
   import axis_bf_pkg::*;
#(
   parameter int SSAMPLE_WIDTH = BF_SAMPLE_WIDTH,
   parameter int WEIGHT_WIDTH  = BF_WEIGHT_WIDTH,
   parameter int PROD_WIDTH    = SSAMPLE_WIDTH + WEIGHT_WIDTH + 1
) (
   input  logic                            clock,
   input  logic                            resetn,
   input  logic                            en,
   input  logic signed [SSAMPLE_WIDTH-1:0] xr,
   input  logic signed [SSAMPLE_WIDTH-1:0] xi,
   input  logic signed [WEIGHT_WIDTH-1:0]  wr,
   input  logic signed [WEIGHT_WIDTH-1:0]  wi,
   output logic signed [SSAMPLE_WIDTH-1:0] yr,
   output logic signed [SSAMPLE_WIDTH-1:0] yi
);

   localparam int MW = SSAMPLE_WIDTH + WEIGHT_WIDTH;

   logic signed [MW-1:0]         p_rr, p_ii, p_ri, p_ir;
   logic signed [PROD_WIDTH-1:0] re_sum, im_sum, re_sh, im_sh;
   logic        [SSAMPLE_WIDTH-1:0] re_fit, im_fit;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         p_rr <= '0;
         p_ii <= '0;
         p_ri <= '0;
         p_ir <= '0;
      end else if (en) begin
         p_rr <= MW'(xr) * MW'(wr);
         p_ii <= MW'(xi) * MW'(wi);
         p_ri <= MW'(xr) * MW'(wi);
         p_ir <= MW'(xi) * MW'(wr);
      end
   end

   always_comb begin
      re_sum = PROD_WIDTH'(p_rr) - PROD_WIDTH'(p_ii);
      im_sum = PROD_WIDTH'(p_ri) + PROD_WIDTH'(p_ir);
      re_sh  = (re_sum + PROD_WIDTH'(ROUND_CONST)) >>> WEIGHT_FRAC;
      im_sh  = (im_sum + PROD_WIDTH'(ROUND_CONST)) >>> WEIGHT_FRAC;
   end

`ifdef AXIS_CWEIGHT_SAT_EN
   localparam logic signed [PROD_WIDTH-1:0] SAT_MAX = PROD_WIDTH'((1 << (SSAMPLE_WIDTH-1)) - 1);
   localparam logic signed [PROD_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic [SSAMPLE_WIDTH-1:0] clamp(input logic signed [PROD_WIDTH-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[SSAMPLE_WIDTH-1:0];
      else if (v < SAT_MIN) return SAT_MIN[SSAMPLE_WIDTH-1:0];
      else                  return v[SSAMPLE_WIDTH-1:0];
   endfunction

   always_comb begin
      re_fit = clamp(re_sh);
      im_fit = clamp(im_sh);
   end
`else
   // Two's-complement wrap keeps arithmetic consistent with the downstream adder
   logic unused_hi;
   assign unused_hi = ^{re_sh[PROD_WIDTH-1:SSAMPLE_WIDTH], im_sh[PROD_WIDTH-1:SSAMPLE_WIDTH]};

   always_comb begin
      re_fit = re_sh[SSAMPLE_WIDTH-1:0];
      im_fit = im_sh[SSAMPLE_WIDTH-1:0];
   end
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         yr <= '0;
         yi <= '0;
      end else if (en) begin
         yr <= re_fit;
         yi <= im_fit;
      end
   end

endmodule : cmult_lane
`default_nettype wire

// File: rtl/axis_cweight_mult.sv
`default_nettype none
// ============================================================================
//  Module   : axis_cweight_mult
//  Purpose  : Per-channel complex weighting of paired real/imag AXI streams;
//             weights commit only between packets. Build option
//             AXIS_CWEIGHT_SAT_EN saturates results instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module axis_cweight_mult
   import axis_bf_pkg::*;
#(
   parameter int SDATA_WIDTH   = BF_DATA_WIDTH,
   parameter int SSAMPLE_WIDTH = BF_SAMPLE_WIDTH,
   parameter int WEIGHT_WIDTH  = BF_WEIGHT_WIDTH,
   parameter int SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH,
   parameter int PROD_WIDTH    = SSAMPLE_WIDTH + WEIGHT_WIDTH + 1
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      s_axis_real_tvalid,
   output logic                      s_axis_real_tready,
   input  logic                      s_axis_real_tlast,
   input  logic [SDATA_WIDTH-1:0]    s_axis_real_tdata,
   input  logic                      s_axis_imag_tvalid,
   output logic                      s_axis_imag_tready,
   input  logic                      s_axis_imag_tlast,
   input  logic [SDATA_WIDTH-1:0]    s_axis_imag_tdata,
   input  logic                      w_tvalid,
   output logic                      w_tready,
   input  logic [2*WEIGHT_WIDTH-1:0] w_tdata,
   output logic [SDATA_WIDTH-1:0]    m_axis_real_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0]  m_axis_real_s2mm_tkeep,
   output logic                      m_axis_real_s2mm_tvalid,
   output logic                      m_axis_real_s2mm_tlast,
   input  logic                      m_axis_real_s2mm_tready,
   output logic [SDATA_WIDTH-1:0]    m_axis_imag_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0]  m_axis_imag_s2mm_tkeep,
   output logic                      m_axis_imag_s2mm_tvalid,
   output logic                      m_axis_imag_s2mm_tlast,
   input  logic                      m_axis_imag_s2mm_tready,
   output logic                      err_tlast_mismatch
);

   localparam int KEEP_W = SDATA_WIDTH / 8;

   pkt_state_t                state, state_nxt;
   logic [2*WEIGHT_WIDTH-1:0] weight_act, weight_shadow;
   logic                      pending;
   logic                      s1_valid, s1_last, s2_valid, s2_last;
   logic                      err;
   logic                      advance, commit, in_ready, accept, w_hs;
   logic signed [WEIGHT_WIDTH-1:0] wr, wi;

   always_comb begin
      advance  = !s2_valid || (m_axis_real_s2mm_tready && m_axis_imag_s2mm_tready);
      commit   = (state == ST_IDLE) && pending;
      in_ready = advance && !commit;
      accept   = s_axis_real_tvalid && s_axis_imag_tvalid && in_ready;
      w_hs     = w_tvalid && !pending;
      wr       = weight_act[WEIGHT_WIDTH-1:0];
      wi       = weight_act[2*WEIGHT_WIDTH-1:WEIGHT_WIDTH];
   end

   // Ready outputs must read 0 for the whole time reset is held
   assign s_axis_real_tready = resetn && in_ready;
   assign s_axis_imag_tready = resetn && in_ready;
   assign w_tready           = resetn && !pending;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept) begin
         case (state)
            ST_IDLE:   if (!s_axis_real_tlast) state_nxt = ST_IN_PKT;
            ST_IN_PKT: if (s_axis_real_tlast)  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         weight_act    <= (2*WEIGHT_WIDTH)'(UNITY_WEIGHT);
         weight_shadow <= '0;
         pending       <= 1'b0;
      end else if (commit) begin
         weight_act    <= weight_shadow;
         pending       <= 1'b0;
      end else if (w_hs) begin
         weight_shadow <= w_tdata;
         pending       <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (advance) begin
            s1_valid <= accept;
            s1_last  <= s_axis_real_tlast;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
         end
         if (accept && (s_axis_real_tlast != s_axis_imag_tlast)) err <= 1'b1;
      end
   end

   for (genvar g = 0; g < SAMPLES; g++) begin : g_lane
      cmult_lane #(
         .SSAMPLE_WIDTH (SSAMPLE_WIDTH),
         .WEIGHT_WIDTH  (WEIGHT_WIDTH),
         .PROD_WIDTH    (PROD_WIDTH)
      ) u_lane (
         .clock  (clock),
         .resetn (resetn),
         .en     (advance),
         .xr     (s_axis_real_tdata[g*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]),
         .xi     (s_axis_imag_tdata[g*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]),
         .wr     (wr),
         .wi     (wi),
         .yr     (m_axis_real_s2mm_tdata[g*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]),
         .yi     (m_axis_imag_s2mm_tdata[g*SSAMPLE_WIDTH +: SSAMPLE_WIDTH])
      );
   end

   assign m_axis_real_s2mm_tvalid = s2_valid;
   assign m_axis_imag_s2mm_tvalid = s2_valid;
   assign m_axis_real_s2mm_tlast  = s2_last;
   assign m_axis_imag_s2mm_tlast  = s2_last;
   assign m_axis_real_s2mm_tkeep  = {KEEP_W{s2_valid}};
   assign m_axis_imag_s2mm_tkeep  = {KEEP_W{s2_valid}};
   assign err_tlast_mismatch      = err;

endmodule : axis_cweight_mult
`default_nettype wire
